// File: rtl/ace_dispatch_if.sv
// rtl/ace_dispatch_if.sv - decoder-group, reservation-station and exception signals of ace_dispatch
interface ace_dispatch_if #(
    parameter int UOP_W = 28
);
    logic [3:0]       dec_vld_i;
    logic [UOP_W-1:0] dec_uop0_i;
    logic [UOP_W-1:0] dec_uop1_i;
    logic [UOP_W-1:0] dec_uop2_i;
    logic [UOP_W-1:0] dec_uop3_i;
    logic [3:0]       dec_rs_id_i;
    logic [3:0]       dec_illegal_i;
    logic             dec_rdy_o;
    logic             rs0_vld_o;
    logic [UOP_W-1:0] rs0_uop_o;
    logic             rs1_vld_o;
    logic [UOP_W-1:0] rs1_uop_o;
    logic             rs0_crd_ret_i;
    logic             rs1_crd_ret_i;
    logic             excp_o;
    logic [1:0]       excp_slot_o;

    modport master (
        output dec_vld_i, dec_uop0_i, dec_uop1_i, dec_uop2_i, dec_uop3_i,
        output dec_rs_id_i, dec_illegal_i, rs0_crd_ret_i, rs1_crd_ret_i,
        input  dec_rdy_o, rs0_vld_o, rs0_uop_o, rs1_vld_o, rs1_uop_o,
        input  excp_o, excp_slot_o
    );

    modport slave (
        input  dec_vld_i, dec_uop0_i, dec_uop1_i, dec_uop2_i, dec_uop3_i,
        input  dec_rs_id_i, dec_illegal_i, rs0_crd_ret_i, rs1_crd_ret_i,
        output dec_rdy_o, rs0_vld_o, rs0_uop_o, rs1_vld_o, rs1_uop_o,
        output excp_o, excp_slot_o
    );
endinterface

// File: rtl/ace_dispatch.sv
// rtl/ace_dispatch.sv - in-order dispatch of a 4-wide decoded group to two credit-tracked reservation stations
module ace_dispatch #(
    parameter int UOP_W    = 28,
    parameter int RS_DEPTH = 8,
    parameter int CRD_W    = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush_i,
    ace_dispatch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DISP, EXCP} state_t;

    localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(RS_DEPTH);

    state_t           state, state_nxt;
    logic [3:0]       grp_vld;
    logic [3:0]       grp_rs;
    logic [3:0]       grp_ill;
    logic [UOP_W-1:0] grp_uop [4];
    logic [1:0]       head;
    logic [CRD_W-1:0] crd0, crd1;

    logic             rs0_vld, rs1_vld, excp;
    logic [UOP_W-1:0] rs0_uop, rs1_uop;
    logic [1:0]       excp_slot;

    logic             use0, use1, excp_hit, all_done, dec_rdy, capture, scan_stop;
    logic [UOP_W-1:0] sel_uop0, sel_uop1;
    logic [2:0]       adv, idx, nxt_idx;
    logic [3:0]       run_mask;

    // Program-order scan from head: stop at the first slot that cannot go this cycle.
    always_comb begin
        scan_stop = (state != DISP);
        use0      = 1'b0;
        use1      = 1'b0;
        sel_uop0  = '0;
        sel_uop1  = '0;
        adv       = 3'd0;
        excp_hit  = 1'b0;
        idx       = 3'd0;
        for (int i = 0; i < 4; i++) begin
            idx = {1'b0, head} + 3'(i);
            if (!scan_stop) begin
                if (idx > 3'd3 || !grp_vld[idx[1:0]]) begin
                    scan_stop = 1'b1;
                end else if (grp_ill[idx[1:0]]) begin
                    scan_stop = 1'b1;
                    excp_hit  = (i == 0);
                end else if (!grp_rs[idx[1:0]]) begin
                    if (crd0 != '0 && !use0) begin
                        use0     = 1'b1;
                        sel_uop0 = grp_uop[idx[1:0]];
                        adv      = adv + 3'd1;
                    end else begin
                        scan_stop = 1'b1;
                    end
                end else begin
                    if (crd1 != '0 && !use1) begin
                        use1     = 1'b1;
                        sel_uop1 = grp_uop[idx[1:0]];
                        adv      = adv + 3'd1;
                    end else begin
                        scan_stop = 1'b1;
                    end
                end
            end
        end
        nxt_idx  = {1'b0, head} + adv;
        all_done = (nxt_idx > 3'd3) || !grp_vld[nxt_idx[1:0]];
    end

    always_comb begin
        run_mask[0] = bus.dec_vld_i[0];
        for (int i = 1; i < 4; i++) begin
            run_mask[i] = run_mask[i-1] & bus.dec_vld_i[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (capture) state_nxt = DISP;
                DISP: begin
                    if (excp_hit)                  state_nxt = EXCP;
                    else if (all_done && !capture) state_nxt = IDLE;
                end
                EXCP:    state_nxt = EXCP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        dec_rdy = 1'b0;
        if (!flush_i) begin
            case (state)
                IDLE:    dec_rdy = 1'b1;
                DISP:    dec_rdy = !excp_hit && all_done;
                default: dec_rdy = 1'b0;
            endcase
        end
        capture = bus.dec_vld_i[0] && dec_rdy;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grp_vld <= '0;
            grp_rs  <= '0;
            grp_ill <= '0;
            head    <= 2'd0;
            for (int i = 0; i < 4; i++) grp_uop[i] <= '0;
        end else if (flush_i) begin
            grp_vld <= '0;
            head    <= 2'd0;
        end else if (capture) begin
            grp_vld    <= run_mask;
            grp_rs     <= bus.dec_rs_id_i;
            grp_ill    <= bus.dec_illegal_i;
            grp_uop[0] <= bus.dec_uop0_i;
            grp_uop[1] <= bus.dec_uop1_i;
            grp_uop[2] <= bus.dec_uop2_i;
            grp_uop[3] <= bus.dec_uop3_i;
            head       <= 2'd0;
        end else if (state == DISP && !excp_hit) begin
            if (all_done) grp_vld <= '0;
            else          head    <= nxt_idx[1:0];
        end
    end

    // A return with no dispatch saturates at full; return plus dispatch cancels out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crd0 <= CRD_FULL;
            crd1 <= CRD_FULL;
        end else if (flush_i) begin
            crd0 <= CRD_FULL;
            crd1 <= CRD_FULL;
        end else begin
            if (use0 && !bus.rs0_crd_ret_i)                    crd0 <= crd0 - 1'b1;
            else if (!use0 && bus.rs0_crd_ret_i && crd0 != CRD_FULL) crd0 <= crd0 + 1'b1;
            if (use1 && !bus.rs1_crd_ret_i)                    crd1 <= crd1 - 1'b1;
            else if (!use1 && bus.rs1_crd_ret_i && crd1 != CRD_FULL) crd1 <= crd1 + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rs0_vld   <= 1'b0;
            rs1_vld   <= 1'b0;
            rs0_uop   <= '0;
            rs1_uop   <= '0;
            excp      <= 1'b0;
            excp_slot <= 2'd0;
        end else if (flush_i) begin
            rs0_vld <= 1'b0;
            rs1_vld <= 1'b0;
            excp    <= 1'b0;
        end else begin
            rs0_vld <= use0;
            rs1_vld <= use1;
            if (use0) rs0_uop <= sel_uop0;
            if (use1) rs1_uop <= sel_uop1;
            if (excp_hit) begin
                excp      <= 1'b1;
                excp_slot <= head;
            end
        end
    end

    assign bus.dec_rdy_o   = dec_rdy;
    assign bus.rs0_vld_o   = rs0_vld;
    assign bus.rs0_uop_o   = rs0_uop;
    assign bus.rs1_vld_o   = rs1_vld;
    assign bus.rs1_uop_o   = rs1_uop;
    assign bus.excp_o      = excp;
    assign bus.excp_slot_o = excp_slot;
endmodule

// File: tb/tb_ace_dispatch.sv
// tb/tb_ace_dispatch.sv - directed scoreboard bench for ace_dispatch
module tb_ace_dispatch;
    localparam int UOP_W = 28;

    logic clock = 1'b0;
    logic reset_n;
    logic flush_i;

    ace_dispatch_if #(.UOP_W(UOP_W)) bus ();

    ace_dispatch #(.UOP_W(UOP_W), .RS_DEPTH(8), .CRD_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    logic [UOP_W-1:0] q0[$];
    logic [UOP_W-1:0] q1[$];
    logic [UOP_W-1:0] uid = 28'hA00_0000;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard: each dispatched uop must be the next expected one for that RS.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (bus.rs0_vld_o) begin
                logic [UOP_W-1:0] e0;
                e0 = (q0.size() > 0) ? q0.pop_front() : 'x;
                total++;
                assert (bus.rs0_uop_o === e0) passed++;
                else $error("FAIL rs0_uop observed=%0h expected=%0h", bus.rs0_uop_o, e0);
            end
            if (bus.rs1_vld_o) begin
                logic [UOP_W-1:0] e1;
                e1 = (q1.size() > 0) ? q1.pop_front() : 'x;
                total++;
                assert (bus.rs1_uop_o === e1) passed++;
                else $error("FAIL rs1_uop observed=%0h expected=%0h", bus.rs1_uop_o, e1);
            end
        end
    end

    // Drives a group, pushes the uops expected to dispatch, and waits for its capture edge.
    task automatic send_group(input logic [3:0] vld, input logic [3:0] rs, input logic [3:0] ill);
        logic [UOP_W-1:0] u [4];
        int wait_cnt;
        bit live;
        live = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uid  = uid + 28'd1;
            u[i] = uid;
            live = live && vld[i] && !ill[i];
            if (live) begin
                if (rs[i]) q1.push_back(u[i]);
                else       q0.push_back(u[i]);
            end
        end
        bus.dec_vld_i     = vld;
        bus.dec_rs_id_i   = rs;
        bus.dec_illegal_i = ill;
        bus.dec_uop0_i    = u[0];
        bus.dec_uop1_i    = u[1];
        bus.dec_uop2_i    = u[2];
        bus.dec_uop3_i    = u[3];
        wait_cnt = 0;
        while (!bus.dec_rdy_o && wait_cnt < 50) begin
            step();
            wait_cnt++;
        end
        if (wait_cnt >= 50) check("capture_timeout", 32'(bus.dec_rdy_o), 32'd1);
        step();
        bus.dec_vld_i = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        flush_i = 1'b0;
        bus.dec_vld_i = '0;  bus.dec_rs_id_i = '0;  bus.dec_illegal_i = '0;
        bus.dec_uop0_i = '0; bus.dec_uop1_i = '0;  bus.dec_uop2_i = '0; bus.dec_uop3_i = '0;
        bus.rs0_crd_ret_i = 1'b0;
        bus.rs1_crd_ret_i = 1'b0;
        step(); step();
        check("rst_rs0_vld", 32'(bus.rs0_vld_o), 0);
        check("rst_rs1_vld", 32'(bus.rs1_vld_o), 0);
        check("rst_rs0_uop", 32'(bus.rs0_uop_o), 0);
        check("rst_excp", 32'(bus.excp_o), 0);
        check("rst_excp_slot", 32'(bus.excp_slot_o), 0);
        check("rst_crd0", 32'(dut.crd0), 8);
        reset_n = 1'b1;
        step();
        check("idle_rdy", 32'(bus.dec_rdy_o), 1);

        // All four slots to RS0.
        send_group(4'b1111, 4'b0000, 4'b0000);
        for (int c = 1; c <= 4; c++) begin
            check("t1_rdy", 32'(bus.dec_rdy_o), 32'(c == 4));
            step();
            check("t1_rs0_vld", 32'(bus.rs0_vld_o), 1);
            check("t1_rs1_vld", 32'(bus.rs1_vld_o), 0);
        end
        step();
        check("t1_drained", 32'(bus.rs0_vld_o), 0);
        check("t1_crd0", 32'(dut.crd0), 4);

        // Three more RS0 uops bring credit0 down to 1.
        send_group(4'b0111, 4'b0000, 4'b0000);
        step(); step(); step(); step();
        check("t1b_crd0", 32'(dut.crd0), 1);

        // 0,0,1,1 with credit0 = 1: slot 1 stalls and blocks slots 2/3.
        send_group(4'b1111, 4'b1100, 4'b0000);
        step();
        check("t3_e1_rs0", 32'(bus.rs0_vld_o), 1);
        check("t3_e1_rs1", 32'(bus.rs1_vld_o), 0);
        step();
        check("t3_stall_a", 32'({bus.rs0_vld_o, bus.rs1_vld_o}), 0);
        step();
        check("t3_stall_b", 32'({bus.rs0_vld_o, bus.rs1_vld_o}), 0);
        check("t3_stall_rdy", 32'(bus.dec_rdy_o), 0);
        bus.rs0_crd_ret_i = 1'b1;
        step();
        bus.rs0_crd_ret_i = 1'b0;
        check("t3_ret_cycle", 32'({bus.rs0_vld_o, bus.rs1_vld_o}), 0);
        step();
        check("t3_pair", 32'({bus.rs0_vld_o, bus.rs1_vld_o}), 32'b11);
        step();
        check("t3_last", 32'({bus.rs0_vld_o, bus.rs1_vld_o}), 32'b01);
        check("t3_crd0", 32'(dut.crd0), 0);
        check("t3_crd1", 32'(dut.crd1), 6);
        bus.rs0_crd_ret_i = 1'b1;
        bus.rs1_crd_ret_i = 1'b1;
        repeat (10) step();
        bus.rs0_crd_ret_i = 1'b0;
        bus.rs1_crd_ret_i = 1'b0;
        check("sat_crd0", 32'(dut.crd0), 8);
        check("sat_crd1", 32'(dut.crd1), 8);

        // 0,1,0,1: two dual-dispatch cycles.
        send_group(4'b1111, 4'b1010, 4'b0000);
        check("t2_rdy_c1", 32'(bus.dec_rdy_o), 0);
        step();
        check("t2_pair_a", 32'({bus.rs0_vld_o, bus.rs1_vld_o}), 32'b11);
        step();
        check("t2_pair_b", 32'({bus.rs0_vld_o, bus.rs1_vld_o}), 32'b11);
        check("t2_crd0", 32'(dut.crd0), 6);
        check("t2_crd1", 32'(dut.crd1), 6);
        step();

        // Illegal slot 2 after two legal slots.
        send_group(4'b1111, 4'b0010, 4'b0100);
        step();
        check("t4_pair", 32'({bus.rs0_vld_o, bus.rs1_vld_o}), 32'b11);
        check("t4_no_excp_yet", 32'(bus.excp_o), 0);
        step();
        check("t4_excp_slot", 32'(bus.excp_slot_o), 2);
        for (int c = 0; c < 10; c++) begin
            check("t4_excp_hold", 32'(bus.excp_o), 1);
            check("t4_rdy_low", 32'(bus.dec_rdy_o), 0);
            step();
        end
        flush_i = 1'b1;
        #1;
        check("t4_flush_rdy", 32'(bus.dec_rdy_o), 0);
        step();
        flush_i = 1'b0;
        #1;
        check("t4_excp_clr", 32'(bus.excp_o), 0);
        check("t4_rdy", 32'(bus.dec_rdy_o), 1);
        check("t4_crd0", 32'(dut.crd0), 8);
        check("t4_crd1", 32'(dut.crd1), 8);

        // Flush a half-dispatched RS1 group together with a credit return.
        send_group(4'b1111, 4'b1111, 4'b0000);
        step();
        check("t5_first", 32'(bus.rs1_vld_o), 1);
        flush_i = 1'b1;
        bus.rs1_crd_ret_i = 1'b1;
        step();
        flush_i = 1'b0;
        bus.rs1_crd_ret_i = 1'b0;
        q1.delete();
        check("t5_crd1", 32'(dut.crd1), 8);
        for (int c = 0; c < 3; c++) begin
            check("t5_quiet", 32'({bus.rs0_vld_o, bus.rs1_vld_o}), 0);
            step();
        end
        send_group(4'b0001, 4'b0000, 4'b0000);
        step();
        check("t5_new_slot0", 32'(bus.rs0_vld_o), 1);
        step();

        // Non-contiguous valid mask 1011: slot 3 must be dropped.
        send_group(4'b1011, 4'b0000, 4'b0000);
        step();
        check("t6_s0", 32'(bus.rs0_vld_o), 1);
        step();
        check("t6_s1", 32'(bus.rs0_vld_o), 1);
        step();
        check("t6_no_s3", 32'(bus.rs0_vld_o), 0);
        step();
        check("t6_q0_empty", 32'(q0.size()), 0);
        check("t6_q1_empty", 32'(q1.size()), 0);

        // Asynchronous reset in the middle of a group.
        send_group(4'b1111, 4'b0000, 4'b0000);
        step();
        #2;
        reset_n = 1'b0;
        q0.delete();
        #1;
        check("mid_rst_vld", 32'(bus.rs0_vld_o), 0);
        check("mid_rst_crd0", 32'(dut.crd0), 8);
        check("mid_rst_rdy", 32'(bus.dec_rdy_o), 1);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_quiet", 32'(bus.rs0_vld_o), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
